// File: rtl/i2s_clk_ctrl.sv
// Run/config sequencer for the I2S bclk/lrck divider.
// Start/stop and divider reconfiguration are deferred to an lrck frame
// boundary, followed by a quiet interval with the divider disabled.
module i2s_clk_ctrl #(
  parameter int         SETTLE_CYCLES   = 16,
  parameter int         TIMEOUT_CYCLES  = 4096,
  parameter logic [4:0] DEF_BCLK_FACTOR = 5'd4,
  parameter logic [5:0] DEF_WORD_WIDTH  = 6'd32
) (
  input  logic       mclki,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [4:0] cfg_bclk_factor,
  input  logic [5:0] cfg_word_width,
  input  logic       lrck,
  output logic       div_enable,
  output logic [4:0] div_bclk_factor,
  output logic [5:0] div_word_width,
  output logic       running,
  output logic       cfg_error,
  output logic       timeout
);
  localparam int CMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, SETTLE, APPLY} state_t;

  state_t        state, state_n;
  logic          run_req, run_req_n;
  logic          pend_vld, pend_vld_eff, pend_vld_n;
  logic [4:0]    pend_bclk_factor, pend_f_eff;
  logic [5:0]    pend_word_width, pend_w_eff;
  logic [CW-1:0] cnt, cnt_n;
  logic          lrck_q, fall, accept, cfg_ok, take, tmo_n, counting;

  // next state, request bookkeeping and drain/settle counter
  always_comb begin
    accept       = cfg_valid & cfg_ready;
    cfg_ok       = (cfg_bclk_factor >= 5'd1) && (cfg_bclk_factor <= 5'd16) &&
                   ((cfg_word_width == 6'd16) || (cfg_word_width == 6'd32));
    take         = accept & cfg_ok;
    // stop beats start when both land in the same cycle
    run_req_n    = stop ? 1'b0 : (start ? 1'b1 : run_req);
    fall         = lrck_q & ~lrck;
    pend_vld_eff = pend_vld | take;
    pend_f_eff   = take ? cfg_bclk_factor : pend_bclk_factor;
    pend_w_eff   = take ? cfg_word_width  : pend_word_width;
    state_n      = state;
    tmo_n        = 1'b0;
    case (state)
      IDLE:    if (pend_vld_eff) state_n = APPLY;
               else if (run_req_n) state_n = RUN;
      RUN:     if (stop || take) state_n = DRAIN;
      DRAIN:   if (fall) state_n = SETTLE;
               else if (cnt == TO_LAST) begin
                 state_n = SETTLE;
                 tmo_n   = 1'b1;
               end
      SETTLE:  if (cnt == ST_LAST)
                 state_n = pend_vld_eff ? APPLY : (run_req_n ? RUN : IDLE);
      APPLY:   state_n = run_req_n ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
    counting   = (state_n == DRAIN) || (state_n == SETTLE);
    cnt_n      = (counting && (state_n == state)) ? cnt + 1'b1 : '0;
    pend_vld_n = (state_n == APPLY) ? 1'b0 : pend_vld_eff;
  end

  // state, pending config and registered divider/status outputs
  always_ff @(posedge mclki) begin
    if (rst) begin
      state            <= IDLE;
      run_req          <= 1'b0;
      pend_vld         <= 1'b0;
      pend_bclk_factor <= DEF_BCLK_FACTOR;
      pend_word_width  <= DEF_WORD_WIDTH;
      cnt              <= '0;
      lrck_q           <= 1'b0;
      div_enable       <= 1'b0;
      div_bclk_factor  <= DEF_BCLK_FACTOR;
      div_word_width   <= DEF_WORD_WIDTH;
      running          <= 1'b0;
      cfg_ready        <= 1'b1;
      cfg_error        <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      state    <= state_n;
      run_req  <= run_req_n;
      pend_vld <= pend_vld_n;
      cnt      <= cnt_n;
      lrck_q   <= lrck;
      if (take) begin
        pend_bclk_factor <= cfg_bclk_factor;
        pend_word_width  <= cfg_word_width;
      end
      // divider sees the new ratio while still disabled
      if ((state_n == APPLY) && (state != APPLY)) begin
        div_bclk_factor <= pend_f_eff;
        div_word_width  <= pend_w_eff;
      end
      div_enable <= (state_n == RUN) || (state_n == DRAIN);
      running    <= (state_n == RUN);
      cfg_ready  <= ((state_n == IDLE) || (state_n == RUN)) && !pend_vld_n;
      cfg_error  <= accept & ~cfg_ok;
      timeout    <= tmo_n;
    end
  end
endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Bench for i2s_clk_ctrl: a behavioural model pushes the expected output
// set every cycle; a monitor pops and compares after each edge. Directed
// scenarios are followed by a randomized phase.
module tb_i2s_clk_ctrl;
  localparam int SETTLE = 16;
  localparam int TMO    = 64;

  logic       mclki = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, cfg_valid = 1'b0, lrck = 1'b0;
  logic [4:0] cfg_bclk_factor = '0;
  logic [5:0] cfg_word_width = '0;
  logic       cfg_ready, div_enable, running, cfg_error, timeout;
  logic [4:0] div_bclk_factor;
  logic [5:0] div_word_width;
  logic       force0 = 1'b0;
  int checks = 0, errors = 0, cyc = 0, tmo_seen = 0, err_seen = 0;

  typedef struct packed {
    logic en, run, rdy, err, tmo;
    logic [4:0] f;
    logic [5:0] w;
  } obs_t;
  obs_t exp_q[$];

  i2s_clk_ctrl #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .mclki(mclki), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_bclk_factor(cfg_bclk_factor), .cfg_word_width(cfg_word_width),
    .lrck(lrck), .div_enable(div_enable), .div_bclk_factor(div_bclk_factor),
    .div_word_width(div_word_width), .running(running),
    .cfg_error(cfg_error), .timeout(timeout)
  );

  always #5 mclki = ~mclki;

  // scaled-down divider: lrck toggles while enabled, idles low otherwise
  initial begin
    int lc;
    lc = 0;
    forever begin
      @(negedge mclki); #1;
      if (div_enable !== 1'b1) begin lrck = 1'b0; lc = 0; end
      else if (force0) lrck = 1'b0;
      else begin
        lc++;
        if (lc >= int'(div_bclk_factor) + int'(div_word_width) / 8) begin
          lrck = ~lrck;
          lc = 0;
        end
      end
    end
  end

  // reference model: phases, a drain age and a settle countdown
  localparam int MI = 0, MR = 1, MD = 2, MS = 3, MA = 4;
  int         m_ph = MI, m_age = 0, m_quiet = 0;
  bit         m_want = 0, m_hp = 0, m_rdy = 1, m_lq = 0;
  logic [4:0] m_pf = 5'd4, m_df = 5'd4;
  logic [5:0] m_pw = 6'd32, m_dw = 6'd32;
  always @(posedge mclki) begin
    bit acc, good, bad, fall, tmo;
    obs_t o;
    acc = 0; good = 0; bad = 0; tmo = 0;
    if (rst) begin
      m_ph = MI; m_want = 0; m_hp = 0; m_lq = 0; m_df = 5'd4; m_dw = 6'd32;
    end else begin
      acc  = cfg_valid && m_rdy;
      good = acc && cfg_bclk_factor >= 1 && cfg_bclk_factor <= 16 &&
             (cfg_word_width == 16 || cfg_word_width == 32);
      bad  = acc && !good;
      if (stop) m_want = 0; else if (start) m_want = 1;
      if (good) begin m_pf = cfg_bclk_factor; m_pw = cfg_word_width; m_hp = 1; end
      fall = m_lq && !lrck;
      m_lq = lrck;
      case (m_ph)
        MI: if (m_hp) m_ph = MA; else if (m_want) m_ph = MR;
        MR: if (stop || good) begin m_ph = MD; m_age = 0; end
        MD: begin
          m_age++;
          if (fall) begin m_ph = MS; m_quiet = SETTLE; end
          else if (m_age == TMO) begin m_ph = MS; m_quiet = SETTLE; tmo = 1; end
        end
        MS: begin
          m_quiet--;
          if (m_quiet == 0) m_ph = m_hp ? MA : (m_want ? MR : MI);
        end
        default: m_ph = m_want ? MR : MI;
      endcase
      if (m_ph == MA) begin m_df = m_pf; m_dw = m_pw; m_hp = 0; end
    end
    m_rdy = (m_ph == MI || m_ph == MR) && !m_hp;
    o.en = (m_ph == MR || m_ph == MD);
    o.run = (m_ph == MR);
    o.rdy = m_rdy;
    o.err = bad;
    o.tmo = tmo;
    o.f = m_df;
    o.w = m_dw;
    exp_q.push_back(o);
  end

  // monitor: compare the full output set after every edge
  initial begin
    obs_t e, a;
    forever begin
      @(posedge mclki); #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.en = div_enable; a.run = running; a.rdy = cfg_ready; a.err = cfg_error;
        a.tmo = timeout; a.f = div_bclk_factor; a.w = div_word_width;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard cyc=%0d act en=%b run=%b rdy=%b err=%b tmo=%b f=%0d w=%0d exp en=%b run=%b rdy=%b err=%b tmo=%b f=%0d w=%0d",
                   cyc, a.en, a.run, a.rdy, a.err, a.tmo, a.f, a.w,
                   e.en, e.run, e.rdy, e.err, e.tmo, e.f, e.w);
        end
        if (timeout === 1'b1) tmo_seen++;
        if (cfg_error === 1'b1) err_seen++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge mclki);
  endtask

  task automatic chk(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, expv);
    end
  endtask

  task automatic send_cfg(int f, int w);
    bit acc, done;
    done = 0;
    cfg_valid = 1'b1;
    cfg_bclk_factor = 5'(f);
    cfg_word_width = 6'(w);
    for (int i = 0; i < 300 && !done; i++) begin
      acc = cfg_ready;
      tick();
      done = acc;
    end
    cfg_valid = 1'b0;
    chk("cfg_handshake", int'(done), 1);
  endtask

  task automatic wait_en(string nm, bit val);
    int n;
    n = 0;
    while (div_enable !== val && n < 300) begin tick(); n++; end
    chk(nm, int'(div_enable), int'(val));
  endtask

  initial begin
    int n, lo, es, ts;
    tick();
    rst = 1'b1; tick(3); rst = 1'b0;
    chk("rst_en", div_enable, 0); chk("rst_f", div_bclk_factor, 4);
    chk("rst_w", div_word_width, 32); chk("rst_rdy", cfg_ready, 1);
    chk("rst_run", running, 0);

    // start: enable and running one cycle later
    tick(6); start = 1'b1; tick(); start = 1'b0;
    chk("start_en", div_enable, 1); chk("start_run", running, 1);

    // reconfigure while running
    tick(5);
    send_cfg(8, 16);
    chk("reconf_drain_en", div_enable, 1);
    wait_en("reconf_drop", 1'b0);
    lo = 0;
    while (div_enable !== 1'b1 && lo < 100) begin lo++; tick(); end
    chk("reconf_low_len", lo, SETTLE + 1);
    chk("reconf_f", div_bclk_factor, 8); chk("reconf_w", div_word_width, 16);
    chk("reconf_run", running, 1);

    // invalid config in RUN: error pulse, no drain
    tick(3); es = err_seen;
    send_cfg(4, 24); tick();
    chk("inv_run_err", err_seen - es, 1);
    tick(30); chk("inv_run_stay", running, 1);

    // graceful stop
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_drain_en", div_enable, 1);
    wait_en("stop_drop", 1'b0);
    tick(SETTLE + 2);
    chk("stop_idle_run", running, 0); chk("stop_idle_en", div_enable, 0);
    chk("stop_idle_rdy", cfg_ready, 1);

    // invalid config in IDLE
    es = err_seen;
    send_cfg(0, 32); tick();
    chk("inv_idle_err", err_seen - es, 1);
    chk("inv_idle_f", div_bclk_factor, 8); chk("inv_idle_en", div_enable, 0);

    // start and stop together
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    tick(3); chk("ss_en", div_enable, 0); chk("ss_run", running, 0);

    // start with config in the same IDLE cycle: apply first, then run
    start = 1'b1; cfg_valid = 1'b1; cfg_bclk_factor = 5'd2; cfg_word_width = 6'd32;
    tick(); start = 1'b0; cfg_valid = 1'b0;
    chk("sc_apply_f", div_bclk_factor, 2); chk("sc_apply_en", div_enable, 0);
    tick(); chk("sc_run_en", div_enable, 1); chk("sc_run", running, 1);

    // drain timeout with lrck stuck low
    tick(4);
    n = 0;
    while (lrck !== 1'b0 && n < 100) begin tick(); n++; end
    force0 = 1'b1; tick(3);
    ts = tmo_seen;
    stop = 1'b1; tick(); stop = 1'b0;
    n = 1;
    while (timeout !== 1'b1 && n < 200) begin tick(); n++; end
    chk("tmo_latency", n, TMO + 1);
    chk("tmo_pulse", tmo_seen - ts, 1);
    force0 = 1'b0;
    tick(SETTLE + 2);
    chk("tmo_idle_en", div_enable, 0); chk("tmo_idle_run", running, 0);

    // reset during SETTLE with a config pending
    start = 1'b1; tick(); start = 1'b0; tick(5);
    send_cfg(3, 16);
    wait_en("rs_drop", 1'b0);
    tick(4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rs_f", div_bclk_factor, 4); chk("rs_w", div_word_width, 32);
    chk("rs_en", div_enable, 0); chk("rs_rdy", cfg_ready, 1);
    tick(25);
    chk("rs_discard_f", div_bclk_factor, 4); chk("rs_idle_run", running, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 29) == 0);
      stop = ($urandom_range(0, 49) == 0);
      cfg_valid = ($urandom_range(0, 14) == 0);
      cfg_bclk_factor = 5'($urandom_range(0, 20));
      case ($urandom_range(0, 3))
        0: cfg_word_width = 6'd16;
        1: cfg_word_width = 6'd32;
        2: cfg_word_width = 6'($urandom_range(0, 63));
        default: cfg_word_width = 6'd16;
      endcase
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 149) == 0) force0 = ~force0;
      tick();
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; rst = 1'b0; force0 = 1'b0;
    tick(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_clk_ctrl.md
# i2s_clk_ctrl

Run/configuration sequencer for the I2S clock divider (bclk/lrck generator) on the mclki domain. Owns the divider's `enable`, `bclk_factor` and `word_width` inputs. Accepts start/stop and reconfiguration requests from the register interface and applies them only at an lrck frame boundary, followed by a quiet settle interval, so the codec never sees a truncated frame or a clock ratio change mid-word.

## Interface
- `SETTLE_CYCLES`, 16: mclki cycles with enable low between drain and re-arm (≥1).
- `TIMEOUT_CYCLES`, 4096: max mclki cycles spent waiting for an lrck falling edge in DRAIN (≥2).
- `DEF_BCLK_FACTOR`, 4: reset value of `div_bclk_factor`.
- `DEF_WORD_WIDTH`, 32: reset value of `div_word_width`.
- `mclki` in 1: sole clock, 24.576 MHz × 4.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle run request.
- `stop` in 1: single-cycle graceful stop request.
- `cfg_valid` in 1: new configuration offered.
- `cfg_ready` out 1: configuration accepted on `cfg_valid & cfg_ready`.
- `cfg_bclk_factor` in 5: requested bclk divide factor.
- `cfg_word_width` in 6: requested word width.
- `lrck` in 1: divider lrck output, same clock domain (fed back).
- `div_enable` out 1: to divider `enable`.
- `div_bclk_factor` out 5: to divider `bclk_factor`.
- `div_word_width` out 6: to divider `word_width`.
- `running` out 1: high iff state is RUN.
- `cfg_error` out 1: one-cycle pulse, accepted config was invalid and discarded.
- `timeout` out 1: one-cycle pulse, DRAIN ended by timeout.

## Operation
- States: IDLE, RUN, DRAIN, SETTLE, APPLY. All outputs are registered.
- `run_req` flag: set by `start`, cleared by `stop`. If both arrive in the same cycle, `stop` wins. Both are honoured in any state.
- `cfg_ready` = 1 in IDLE and RUN only, while no pending config is held.
- Valid config: `cfg_bclk_factor` in 1..16 and `cfg_word_width` in {16, 32}.
  - An invalid config is still accepted (ready handshake completes), then dropped.
  - `cfg_error` pulses the cycle after acceptance. State and outputs are unchanged.
- On acceptance, a valid config is captured into `pend_*` and `pend_vld` is set.
- IDLE transitions:
  - `pend_vld` → APPLY.
  - else `run_req` → RUN.
- RUN: `stop` or valid config accepted → DRAIN.
- DRAIN:
  - `div_enable` stays 1.
  - `lrck_q` registers `lrck`; a falling edge is `lrck_q & ~lrck`.
  - On a falling edge, or when the DRAIN cycle counter reaches TIMEOUT_CYCLES → SETTLE. The timeout case also pulses `timeout`.
- SETTLE: counts SETTLE_CYCLES. Then `pend_vld` → APPLY; else `run_req` → RUN; else → IDLE.
- APPLY:
  - Lasts 1 cycle. `div_*` take `pend_*` on entry and `pend_vld` clears.
  - Then `run_req` → RUN, else → IDLE.
- `div_enable` = 1 in RUN and DRAIN, 0 elsewhere.
- Reset mid-operation:
  - State → IDLE; `run_req`, `pend_vld` and counters clear.
  - `div_*` return to their defaults.
  - No drain is attempted.

## Timing
- Reset values: `div_enable`=0, `div_bclk_factor`=DEF_BCLK_FACTOR, `div_word_width`=DEF_WORD_WIDTH, `running`=0, `cfg_error`=0, `timeout`=0, `cfg_ready`=1 from the first cycle after reset.
- `start` at edge n in IDLE (no pending config): `div_enable`=`running`=1 from cycle n+1.
- Config accepted at edge n in IDLE:
  - APPLY during n+1, and the new `div_*` are visible in n+1.
  - If `run_req`, `div_enable` rises at n+2. The config is therefore stable for ≥1 cycle before enable.
- `stop`/config at edge n in RUN:
  - DRAIN from n+1.
  - lrck falling edge seen at edge m → `div_enable`=0 from m+1.
  - SETTLE occupies m+1 .. m+SETTLE_CYCLES.
  - APPLY at m+SETTLE_CYCLES+1, if a config is pending.
- `start` and `cfg_valid` in the same IDLE cycle: the config is applied first, then RUN.
- `stop` with a config in RUN: drain, apply, end in IDLE.
- `start` during DRAIN/SETTLE after a `stop`: `run_req` re-set, so the sequence ends in RUN.
- A second `cfg_valid` while `pend_vld` is set: `cfg_ready` is 0, so it stalls until APPLY completes.

## Test plan
- Reset, then `start`:
  - After reset: `div_enable`=0, factor=4, width=32.
  - `start` at cycle 10 → `div_enable`=1 at cycle 11; `running`=1.
- Reconfigure while running: RUN, cfg (8, 16) accepted.
  - `div_enable` holds 1 until the cycle after the next lrck falling edge, then is 0 for 16 cycles.
  - APPLY sets factor=8, width=16; enable returns 1 the next cycle.
  - No lrck edge is cut short before the drain point.
- Invalid config:
  - cfg (0, 32) in IDLE → `cfg_error` pulse, outputs unchanged.
  - cfg (4, 24) in RUN → `cfg_error` pulse, stays RUN, no drain.
- Graceful stop: `stop` in RUN → enable drops only after an lrck falling edge; after 16 settle cycles, IDLE with `running`=0.
- Drain timeout: lrck held at 0 in DRAIN (TIMEOUT_CYCLES=64) → `timeout` pulses after 64 cycles, then SETTLE proceeds normally.
- Collisions and reset:
  - `start`+`stop` in the same cycle → stays IDLE.
  - `rst` asserted in SETTLE with a config pending → IDLE, defaults restored, pending config discarded.
